// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter for the single register-file access port.
// One transaction in flight; reads wait for read-valid with a bounded timeout.
module rf_access_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_REQ0_VLD,
   input  logic                  i_REQ0_WR,
   input  logic [ADDR_WIDTH-1:0] i_REQ0_ADDR,
   input  logic [DATA_WIDTH-1:0] i_REQ0_WDATA,
   output logic                  o_REQ0_ACK,
   output logic [DATA_WIDTH-1:0] o_REQ0_RDATA,
   output logic                  o_REQ0_ERR,
   input  logic                  i_REQ1_VLD,
   input  logic                  i_REQ1_WR,
   input  logic [ADDR_WIDTH-1:0] i_REQ1_ADDR,
   input  logic [DATA_WIDTH-1:0] i_REQ1_WDATA,
   output logic                  o_REQ1_ACK,
   output logic [DATA_WIDTH-1:0] o_REQ1_RDATA,
   output logic                  o_REQ1_ERR,
   output logic                  o_RF_WrEn,
   output logic                  o_RF_RdEn,
   output logic [ADDR_WIDTH-1:0] o_RF_Address,
   output logic [DATA_WIDTH-1:0] o_RF_WrData,
   input  logic [DATA_WIDTH-1:0] i_RF_RdData,
   input  logic                  i_RF_RdData_Valid,
   output logic                  o_BUSY
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      READ_WAIT
   } state_t;

   state_t           state;
   logic             ptr;       // side that wins when both requesters are valid
   logic             owner;
   logic             cur_wr;
   logic [CNT_W-1:0] rd_cnt;

   logic                  grant_any;
   logic                  grant_sel;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant_sel = ptr;
      if (i_REQ0_VLD && !i_REQ1_VLD)
         grant_sel = 1'b0;
      else if (!i_REQ0_VLD && i_REQ1_VLD)
         grant_sel = 1'b1;
      grant_any = i_REQ0_VLD | i_REQ1_VLD;
      sel_wr    = grant_sel ? i_REQ1_WR    : i_REQ0_WR;
      sel_addr  = grant_sel ? i_REQ1_ADDR  : i_REQ0_ADDR;
      sel_wdata = grant_sel ? i_REQ1_WDATA : i_REQ0_WDATA;
   end

   // NOTE: state and registered outputs use non-blocking assignments only.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         owner        <= 1'b0;
         cur_wr       <= 1'b0;
         rd_cnt       <= '0;
         o_REQ0_ACK   <= 1'b0;
         o_REQ0_RDATA <= '0;
         o_REQ0_ERR   <= 1'b0;
         o_REQ1_ACK   <= 1'b0;
         o_REQ1_RDATA <= '0;
         o_REQ1_ERR   <= 1'b0;
         o_RF_WrEn    <= 1'b0;
         o_RF_RdEn    <= 1'b0;
         o_RF_Address <= '0;
         o_RF_WrData  <= '0;
         o_BUSY       <= 1'b0;
      end else begin
         // Strobes and handshake pulses last a single cycle.
         o_RF_WrEn  <= 1'b0;
         o_RF_RdEn  <= 1'b0;
         o_REQ0_ACK <= 1'b0;
         o_REQ0_ERR <= 1'b0;
         o_REQ1_ACK <= 1'b0;
         o_REQ1_ERR <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner        <= grant_sel;
                  cur_wr       <= sel_wr;
                  ptr          <= ~grant_sel;
                  o_RF_Address <= sel_addr;
                  o_BUSY       <= 1'b1;
                  state        <= ISSUE;
                  if (sel_wr) begin
                     // Writes complete in ISSUE, so the ACK rides with the strobe.
                     o_RF_WrData <= sel_wdata;
                     o_RF_WrEn   <= 1'b1;
                     if (grant_sel) o_REQ1_ACK <= 1'b1;
                     else           o_REQ0_ACK <= 1'b1;
                  end else begin
                     o_RF_RdEn <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               if (cur_wr) begin
                  state  <= IDLE;
                  o_BUSY <= 1'b0;
               end else begin
                  rd_cnt <= '0;
                  state  <= READ_WAIT;
               end
            end

            READ_WAIT: begin
               if (i_RF_RdData_Valid) begin
                  if (owner) begin
                     o_REQ1_RDATA <= i_RF_RdData;
                     o_REQ1_ACK   <= 1'b1;
                  end else begin
                     o_REQ0_RDATA <= i_RF_RdData;
                     o_REQ0_ACK   <= 1'b1;
                  end
                  state  <= IDLE;
                  o_BUSY <= 1'b0;
               end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                  // Final waiting cycle without data: saturate and report the error.
                  rd_cnt <= CNT_W'(RD_TIMEOUT);
                  if (owner) begin
                     o_REQ1_RDATA <= '0;
                     o_REQ1_ACK   <= 1'b1;
                     o_REQ1_ERR   <= 1'b1;
                  end else begin
                     o_REQ0_RDATA <= '0;
                     o_REQ0_ACK   <= 1'b1;
                     o_REQ0_ERR   <= 1'b1;
                  end
                  state  <= IDLE;
                  o_BUSY <= 1'b0;
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               o_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule
